// File: rtl/wash_sensor_timer.sv
// Sensor conditioning and wash-phase timing for the washing machine controller.
// Three raw drum switches are synchronised and debounced into clean levels, a
// small FSM times the wash phase, and two watchdogs flag a fill or drain that
// never completes.
module wash_sensor_timer #(
  parameter int DEBOUNCE    = 4,
  parameter int WASH_CYCLES = 16,
  parameter int FILL_LIMIT  = 64,
  parameter int DRAIN_LIMIT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level_hi_raw,
  input  logic       level_lo_raw,
  input  logic       soap_raw,
  input  logic       water_valve,
  input  logic       motor,
  input  logic       drain_valve,
  output logic       filled,
  output logic       drained,
  output logic       detergent_add,
  output logic       cycle_timeout,
  output logic [1:0] fault
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timerState_e;

  localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE - 1);
  localparam logic [7:0] WASH_LOAD = 8'(WASH_CYCLES - 1);
  localparam logic [7:0] FILL_LIM  = 8'(FILL_LIMIT);
  localparam logic [7:0] DRAIN_LIM = 8'(DRAIN_LIMIT);

  // Channel order in the sensor vectors: bit0 high-water, bit1 low-water, bit2 soap.
  logic [2:0]      rawVec;
  logic [2:0]      sync1_q;
  logic [2:0]      sync2_q;
  logic [2:0]      deb_q;
  logic [2:0]      deb_d;
  logic [2:0][3:0] dbCnt_q;
  logic [2:0][3:0] dbCnt_d;

  timerState_e     state_q;
  timerState_e     state_d;
  logic [7:0]      washCnt_q;
  logic [7:0]      washCnt_d;

  logic [7:0]      fillCnt_q;
  logic [7:0]      fillCnt_d;
  logic [7:0]      drainCnt_q;
  logic [7:0]      drainCnt_d;
  logic [1:0]      fault_q;
  logic [1:0]      fault_d;

  assign rawVec = {soap_raw, level_lo_raw, level_hi_raw};

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= rawVec;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a mismatch must persist DEBOUNCE edges before the clean level flips.
  always_comb begin
    deb_d   = deb_q;
    dbCnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dbCnt_q[i] == DB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          dbCnt_d[i] = dbCnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Debounced levels and their stability counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q   <= '0;
      dbCnt_q <= '0;
    end else begin
      deb_q   <= deb_d;
      dbCnt_q <= dbCnt_d;
    end
  end

  assign filled        = deb_q[0];
  assign drained       = ~deb_q[1];
  assign detergent_add = deb_q[2];

  // Wash timer: runs while the motor spins, pauses while draining, aborts when the motor stops.
  always_comb begin
    state_d   = state_q;
    washCnt_d = washCnt_q;
    case (state_q)
      IDLE: begin
        if (motor && !drain_valve) begin
          state_d   = RUN;
          washCnt_d = WASH_LOAD;
        end
      end
      RUN: begin
        if (!motor) begin
          state_d   = IDLE;
          washCnt_d = '0;
        end else if (!drain_valve) begin
          if (washCnt_q == 8'd0) begin
            state_d = EXPIRED;
          end else begin
            washCnt_d = washCnt_q - 8'd1;
          end
        end
      end
      EXPIRED: begin
        if (!motor) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        washCnt_d = '0;
      end
    endcase
  end

  // Wash timer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      washCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      washCnt_q <= washCnt_d;
    end
  end

  assign cycle_timeout = (state_q == EXPIRED);

  // Watchdogs: count consecutive edges a valve is open without reaching its level; flags stick.
  always_comb begin
    fillCnt_d  = '0;
    drainCnt_d = '0;
    fault_d    = fault_q;
    if (water_valve && !filled) begin
      fillCnt_d = (fillCnt_q == FILL_LIM) ? fillCnt_q : fillCnt_q + 8'd1;
    end
    if (drain_valve && !drained) begin
      drainCnt_d = (drainCnt_q == DRAIN_LIM) ? drainCnt_q : drainCnt_q + 8'd1;
    end
    if (fillCnt_d == FILL_LIM) begin
      fault_d[0] = 1'b1;
    end
    if (drainCnt_d == DRAIN_LIM) begin
      fault_d[1] = 1'b1;
    end
  end

  // Watchdog counters and sticky fault flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fillCnt_q  <= '0;
      drainCnt_q <= '0;
      fault_q    <= '0;
    end else begin
      fillCnt_q  <= fillCnt_d;
      drainCnt_q <= drainCnt_d;
      fault_q    <= fault_d;
    end
  end

  assign fault = fault_q;

endmodule

// File: tb/tb_wash_sensor_timer.sv
// Directed testbench for wash_sensor_timer: a table of multi-cycle vectors
// followed by hand-written sequences for exact edge timing and async reset.
module tb_wash_sensor_timer;

  logic       clk;
  logic       rst;
  logic       level_hi_raw;
  logic       level_lo_raw;
  logic       soap_raw;
  logic       water_valve;
  logic       motor;
  logic       drain_valve;
  logic       filled;
  logic       drained;
  logic       detergent_add;
  logic       cycle_timeout;
  logic [1:0] fault;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic       hi;
    logic       lo;
    logic       soap;
    logic       water;
    logic       mot;
    logic       drain;
    int         cycles;
    logic       expFilled;
    logic       expDrained;
    logic       expDet;
    logic       expTimeout;
    logic [1:0] expFault;
  } vec_t;

  vec_t vecs[$];

  wash_sensor_timer #(
    .DEBOUNCE    (4),
    .WASH_CYCLES (16),
    .FILL_LIMIT  (64),
    .DRAIN_LIMIT (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .level_hi_raw  (level_hi_raw),
    .level_lo_raw  (level_lo_raw),
    .soap_raw      (soap_raw),
    .water_valve   (water_valve),
    .motor         (motor),
    .drain_valve   (drain_valve),
    .filled        (filled),
    .drained       (drained),
    .detergent_add (detergent_add),
    .cycle_timeout (cycle_timeout),
    .fault         (fault)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    level_hi_raw = v.hi;
    level_lo_raw = v.lo;
    soap_raw     = v.soap;
    water_valve  = v.water;
    motor        = v.mot;
    drain_valve  = v.drain;
    step(v.cycles);
  endtask

  task automatic checkAll(input string tag, input logic f, input logic d, input logic det,
                          input logic t, input logic [1:0] flt);
    checkOutput({tag, " filled"}, {1'b0, filled}, {1'b0, f});
    checkOutput({tag, " drained"}, {1'b0, drained}, {1'b0, d});
    checkOutput({tag, " detergent_add"}, {1'b0, detergent_add}, {1'b0, det});
    checkOutput({tag, " cycle_timeout"}, {1'b0, cycle_timeout}, {1'b0, t});
    checkOutput({tag, " fault"}, fault, flt);
  endtask

  task automatic clearInputs();
    level_hi_raw = 1'b0;
    level_lo_raw = 1'b0;
    soap_raw     = 1'b0;
    water_valve  = 1'b0;
    motor        = 1'b0;
    drain_valve  = 1'b0;
  endtask

  initial begin
    // hi lo soap water motor drain cycles | filled drained det timeout fault
    vecs.push_back('{0,0,0,0,0,0,  3, 0,1,0,0,2'b00});
    vecs.push_back('{0,1,0,0,0,0,  5, 0,1,0,0,2'b00});
    vecs.push_back('{0,1,0,0,0,0,  1, 0,0,0,0,2'b00});
    vecs.push_back('{1,1,1,0,0,0,  5, 0,0,0,0,2'b00});
    vecs.push_back('{1,1,1,0,0,0,  1, 1,0,1,0,2'b00});
    vecs.push_back('{1,1,1,0,1,1,  4, 1,0,1,0,2'b00});
    vecs.push_back('{1,1,1,0,1,0, 16, 1,0,1,0,2'b00});
    vecs.push_back('{1,1,1,0,1,0,  1, 1,0,1,1,2'b00});
    vecs.push_back('{1,1,1,0,1,1,  3, 1,0,1,1,2'b00});
    vecs.push_back('{1,1,1,0,0,0,  1, 1,0,1,0,2'b00});
    vecs.push_back('{1,1,1,0,1,0,  8, 1,0,1,0,2'b00});
    vecs.push_back('{1,1,1,0,0,1,  1, 1,0,1,0,2'b00});
    vecs.push_back('{1,1,1,0,1,0, 17, 1,0,1,1,2'b00});
    vecs.push_back('{0,0,0,0,0,0,  6, 0,1,0,0,2'b00});
    vecs.push_back('{0,0,0,1,0,0, 63, 0,1,0,0,2'b00});
    vecs.push_back('{0,0,0,1,0,0,  1, 0,1,0,0,2'b01});
    vecs.push_back('{0,0,0,0,0,0,  3, 0,1,0,0,2'b01});
    vecs.push_back('{0,1,0,0,0,0,  6, 0,0,0,0,2'b01});
    vecs.push_back('{0,1,0,0,0,1, 63, 0,0,0,0,2'b01});
    vecs.push_back('{0,1,0,0,0,1,  1, 0,0,0,0,2'b11});

    clearInputs();
    rst = 1'b0;
    #3;
    checkAll("reset", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    step(2);
    rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i].expFilled, vecs[i].expDrained,
               vecs[i].expDet, vecs[i].expTimeout, vecs[i].expFault);
    end

    // Sticky faults clear only through reset.
    clearInputs();
    rst = 1'b0;
    #1;
    checkAll("fault reset", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    rst = 1'b1;
    step(1);

    // High-water switch: clean level appears on the sixth edge after the change, not earlier.
    level_hi_raw = 1'b1;
    step(5);
    checkOutput("hi debounce early", {1'b0, filled}, 2'b00);
    step(1);
    checkOutput("hi debounce edge", {1'b0, filled}, 2'b01);

    // A three-cycle soap glitch must never reach detergent_add.
    soap_raw = 1'b1;
    step(3);
    soap_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      checkOutput($sformatf("soap glitch %0d", i), {1'b0, detergent_add}, 2'b00);
    end

    // Uninterrupted wash: timeout on the 17th edge counting the entry edge.
    motor = 1'b1;
    step(16);
    checkOutput("wash early", {1'b0, cycle_timeout}, 2'b00);
    step(1);
    checkOutput("wash expire", {1'b0, cycle_timeout}, 2'b01);
    step(3);
    checkOutput("wash hold", {1'b0, cycle_timeout}, 2'b01);
    motor = 1'b0;
    step(1);
    checkOutput("wash release", {1'b0, cycle_timeout}, 2'b00);

    // Draining for five cycles mid-wash delays the timeout by exactly five.
    motor = 1'b1;
    step(10);
    drain_valve = 1'b1;
    step(5);
    drain_valve = 1'b0;
    step(6);
    checkOutput("pause early", {1'b0, cycle_timeout}, 2'b00);
    step(1);
    checkOutput("pause expire", {1'b0, cycle_timeout}, 2'b01);
    motor = 1'b0;
    step(1);
    checkOutput("pause release", {1'b0, cycle_timeout}, 2'b00);

    // Motor drop during RUN aborts with no timeout pulse; a fresh run restarts the full count.
    motor = 1'b1;
    step(10);
    motor = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checkOutput($sformatf("abort %0d", i), {1'b0, cycle_timeout}, 2'b00);
    end
    motor = 1'b1;
    step(16);
    checkOutput("restart early", {1'b0, cycle_timeout}, 2'b00);
    step(1);
    checkOutput("restart expire", {1'b0, cycle_timeout}, 2'b01);
    motor = 1'b0;
    step(1);

    // Reset between edges while running with all sensors asserted.
    level_lo_raw = 1'b1;
    soap_raw     = 1'b1;
    step(6);
    checkAll("pre-reset", 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    motor = 1'b1;
    step(4);
    checkOutput("pre-reset run", {1'b0, cycle_timeout}, 2'b00);
    #2;
    rst = 1'b0;
    #1;
    checkAll("async reset", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
